// File: rtl/dual_issue_decode.sv
// Dual-issue decode stage: routes a fetched instruction pair onto the even
// (arithmetic) and odd (load/store/branch/shuffle) issue registers, splitting
// unpairable pairs across two cycles while holding fetch.
module dual_issue_decode #(
  parameter int bitsize = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr1_in,
  input  logic [31:0]        instr2_in,
  input  logic [bitsize-1:0] pc_in,
  input  logic               fetch_valid,
  input  logic               stall_in,
  input  logic               flush,
  output logic               pc_enable,
  output logic [31:0]        even_instr,
  output logic               even_valid,
  output logic [bitsize-1:0] even_pc,
  output logic [31:0]        odd_instr,
  output logic               odd_valid,
  output logic [bitsize-1:0] odd_pc
);

  localparam logic [31:0] NOP  = 32'h4020_0000;
  localparam logic [31:0] LNOP = 32'h0020_0000;

  typedef enum logic {PAIR, SPLIT} state_t;

  typedef struct packed {
    logic [31:0]        instr;
    logic               valid;
    logic [bitsize-1:0] pc;
  } slot_t;

  // Filler slots carry PC 0 so an empty slot never leaks a stale address.
  localparam slot_t EVEN_FILL = '{instr: NOP,  valid: 1'b0, pc: {bitsize{1'b0}}};
  localparam slot_t ODD_FILL  = '{instr: LNOP, valid: 1'b0, pc: {bitsize{1'b0}}};

  state_t             state, state_d;
  slot_t              even_q, even_d, odd_q, odd_d;
  logic [31:0]        hold_instr, hold_instr_d;
  logic [bitsize-1:0] hold_pc, hold_pc_d;
  logic [bitsize-1:0] pc_next;
  logic               raw, pairable;
  logic               single;
  logic [31:0]        single_instr;
  logic [bitsize-1:0] single_pc;

  // pc_in+1 wraps naturally at the PC width.
  assign pc_next  = pc_in + bitsize'(1);
  assign raw      = (instr1_in[6:0] == instr2_in[13:7]) ||
                    (instr1_in[6:0] == instr2_in[20:14]);
  assign pairable = !instr1_in[28] && instr2_in[28] && !raw;

  // Fetch may advance unless held by reset/stall or an unpairable pair is being split.
  assign pc_enable = !reset && (flush || !stall_in) &&
                     !(state == PAIR && fetch_valid && !pairable);

  // Next-state and next issue-slot contents.
  always_comb begin
    state_d      = state;
    even_d       = EVEN_FILL;
    odd_d        = ODD_FILL;
    hold_instr_d = hold_instr;
    hold_pc_d    = hold_pc;
    single       = 1'b0;
    single_instr = 32'h0;
    single_pc    = {bitsize{1'b0}};
    case (state)
      PAIR: begin
        if (fetch_valid) begin
          if (pairable) begin
            even_d = '{instr: instr1_in, valid: 1'b1, pc: pc_in};
            odd_d  = '{instr: instr2_in, valid: 1'b1, pc: pc_next};
          end else begin
            single       = 1'b1;
            single_instr = instr1_in;
            single_pc    = pc_in;
            hold_instr_d = instr2_in;
            hold_pc_d    = pc_next;
            state_d      = SPLIT;
          end
        end
      end
      SPLIT: begin
        single       = 1'b1;
        single_instr = hold_instr;
        single_pc    = hold_pc;
        state_d      = PAIR;
      end
      default: state_d = PAIR;
    endcase
    // A lone instruction goes to the slot of its pipe class.
    if (single) begin
      if (single_instr[28]) odd_d  = '{instr: single_instr, valid: 1'b1, pc: single_pc};
      else                  even_d = '{instr: single_instr, valid: 1'b1, pc: single_pc};
    end
  end

  // State, issue and hold registers: reset > flush > stall > advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PAIR;
      even_q     <= EVEN_FILL;
      odd_q      <= ODD_FILL;
      hold_instr <= 32'h0;
      hold_pc    <= {bitsize{1'b0}};
    end else if (flush) begin
      state      <= PAIR;
      even_q     <= EVEN_FILL;
      odd_q      <= ODD_FILL;
      hold_instr <= 32'h0;
      hold_pc    <= {bitsize{1'b0}};
    end else if (!stall_in) begin
      state      <= state_d;
      even_q     <= even_d;
      odd_q      <= odd_d;
      hold_instr <= hold_instr_d;
      hold_pc    <= hold_pc_d;
    end
  end

  assign even_instr = even_q.instr;
  assign even_valid = even_q.valid;
  assign even_pc    = even_q.pc;
  assign odd_instr  = odd_q.instr;
  assign odd_valid  = odd_q.valid;
  assign odd_pc     = odd_q.pc;

endmodule

// File: tb/tb_dual_issue_decode.sv
// Scoreboard bench for dual_issue_decode: each scenario pushes the expected
// issue-register contents when it drives a pair and pops them after the edge.
module tb_dual_issue_decode;

  localparam logic [31:0] NOP  = 32'h4020_0000;
  localparam logic [31:0] LNOP = 32'h0020_0000;

  typedef struct packed {
    logic [31:0] ei; logic ev; logic [10:0] ep;
    logic [31:0] oi; logic ov; logic [10:0] op;
  } out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr1_in = '0, instr2_in = '0;
  logic [10:0] pc_in = '0;
  logic        fetch_valid = 1'b0, stall_in = 1'b0, flush = 1'b0;
  logic        pc_enable;
  logic [31:0] even_instr, odd_instr;
  logic        even_valid, odd_valid;
  logic [10:0] even_pc, odd_pc;

  int checks = 0;
  int errors = 0;
  out_t sb[$];
  out_t got, exp_o;

  dual_issue_decode #(.bitsize(11)) dut (
    .clk(clk), .reset(reset), .instr1_in(instr1_in), .instr2_in(instr2_in),
    .pc_in(pc_in), .fetch_valid(fetch_valid), .stall_in(stall_in), .flush(flush),
    .pc_enable(pc_enable), .even_instr(even_instr), .even_valid(even_valid),
    .even_pc(even_pc), .odd_instr(odd_instr), .odd_valid(odd_valid), .odd_pc(odd_pc)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(logic [31:0] ei, logic ev, logic [10:0] ep,
                              logic [31:0] oi, logic ov, logic [10:0] op);
    mk = '{ei: ei, ev: ev, ep: ep, oi: oi, ov: ov, op: op};
  endfunction

  // PC of a filler slot is not defined, so it is ignored in comparisons.
  function automatic out_t masked(out_t o);
    masked = o;
    if (!o.ev) masked.ep = '0;
    if (!o.ov) masked.op = '0;
  endfunction

  function automatic out_t sample();
    sample = mk(even_instr, even_valid, even_pc, odd_instr, odd_valid, odd_pc);
  endfunction

  task automatic drive(logic [31:0] i1, logic [31:0] i2, logic [10:0] pc,
                       logic fv, logic st, logic fl);
    @(negedge clk);
    instr1_in = i1; instr2_in = i2; pc_in = pc;
    fetch_valid = fv; stall_in = st; flush = fl;
    #1;
  endtask

  task automatic test_reset();
    // Disturb the outputs first, then reset mid-cycle.
    drive(32'h0000_0081, 32'h1000_0102, 11'd9, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    checks++;
    got = sample();
    if (got !== mk(NOP, 1'b0, 11'd0, LNOP, 1'b0, 11'd0)) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", got, mk(NOP, 1'b0, 11'd0, LNOP, 1'b0, 11'd0));
    end
    checks++;
    if (pc_enable !== 1'b0) begin errors++; $display("FAIL reset_pc_enable got=%b exp=0", pc_enable); end
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_pair();
    drive(32'h0000_0081, 32'h1000_0102, 11'd5, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc_enable !== 1'b1) begin errors++; $display("FAIL pair_pc_enable got=%b exp=1", pc_enable); end
    sb.push_back(mk(32'h0000_0081, 1'b1, 11'd5, 32'h1000_0102, 1'b1, 11'd6));
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got = sample(); checks++;
    if (masked(got) !== masked(exp_o)) begin errors++; $display("FAIL pair got=%h exp=%h", got, exp_o); end
  endtask

  task automatic test_raw_split();
    drive(32'h0000_0003, 32'h1000_0180, 11'd10, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc_enable !== 1'b0) begin errors++; $display("FAIL raw_pc_enable_c0 got=%b exp=0", pc_enable); end
    sb.push_back(mk(32'h0000_0003, 1'b1, 11'd10, LNOP, 1'b0, 11'd0));
    sb.push_back(mk(NOP, 1'b0, 11'd0, 32'h1000_0180, 1'b1, 11'd11));
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got = sample(); checks++;
    if (masked(got) !== masked(exp_o)) begin errors++; $display("FAIL raw_c1 got=%h exp=%h", got, exp_o); end
    // New pair presented during SPLIT must be ignored.
    drive(32'h0000_0081, 32'h1000_0102, 11'd12, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc_enable !== 1'b1) begin errors++; $display("FAIL raw_pc_enable_c1 got=%b exp=1", pc_enable); end
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got = sample(); checks++;
    if (masked(got) !== masked(exp_o)) begin errors++; $display("FAIL raw_c2 got=%h exp=%h", got, exp_o); end
  endtask

  task automatic test_class_order();
    drive(32'h1000_0005, 32'h0000_0100, 11'd20, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc_enable !== 1'b0) begin errors++; $display("FAIL order_pc_enable got=%b exp=0", pc_enable); end
    sb.push_back(mk(NOP, 1'b0, 11'd0, 32'h1000_0005, 1'b1, 11'd20));
    sb.push_back(mk(32'h0000_0100, 1'b1, 11'd21, LNOP, 1'b0, 11'd0));
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (c == 0) drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
      else begin end
    end
    // The above loop advanced two edges; re-check is done below per edge.
  endtask

  task automatic test_class_order_checked();
    drive(32'h1000_0005, 32'h0000_0100, 11'd20, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc_enable !== 1'b0) begin errors++; $display("FAIL order_pc_enable got=%b exp=0", pc_enable); end
    sb.push_back(mk(NOP, 1'b0, 11'd0, 32'h1000_0005, 1'b1, 11'd20));
    sb.push_back(mk(32'h0000_0100, 1'b1, 11'd21, LNOP, 1'b0, 11'd0));
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      exp_o = sb.pop_front(); got = sample(); checks++;
      if (masked(got) !== masked(exp_o)) begin errors++; $display("FAIL order_c%0d got=%h exp=%h", c, got, exp_o); end
      drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1 [3];
    logic [31:0] o2 [3];
    logic [10:0] pcs[3];
    e1  = '{32'h0000_0081, 32'h0ABC_0005, 32'h0000_7F7F};
    o2  = '{32'h1000_0102, 32'h1F00_0183, 32'h1000_0000};
    pcs = '{11'h7FF, 11'd100, 11'd200};   // first pair exercises PC wrap
    for (int k = 0; k < 3; k++) begin
      drive(e1[k], o2[k], pcs[k], 1'b1, 1'b0, 1'b0);
      checks++;
      if (pc_enable !== 1'b1) begin errors++; $display("FAIL b2b_pc_enable%0d got=%b exp=1", k, pc_enable); end
      sb.push_back(mk(e1[k], 1'b1, pcs[k], o2[k], 1'b1, pcs[k] + 11'd1));
      @(posedge clk); #1;
      exp_o = sb.pop_front(); got = sample(); checks++;
      if (masked(got) !== masked(exp_o)) begin errors++; $display("FAIL b2b%0d got=%h exp=%h", k, got, exp_o); end
    end
    // Explicit wrap check independent of the model arithmetic.
    drive(32'h0000_0081, 32'h1000_0102, 11'h7FF, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (odd_pc !== 11'h000 || even_pc !== 11'h7FF) begin
      errors++; $display("FAIL pc_wrap got=%h/%h exp=7ff/000", even_pc, odd_pc);
    end
    // Idle cycle: both slots filler.
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk(NOP, 1'b0, 11'd0, LNOP, 1'b0, 11'd0));
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got = sample(); checks++;
    if (masked(got) !== masked(exp_o)) begin errors++; $display("FAIL idle got=%h exp=%h", got, exp_o); end
  endtask

  task automatic test_flush_split();
    drive(32'h0000_0003, 32'h1000_0180, 11'd30, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(32'h0000_0003, 1'b1, 11'd30, LNOP, 1'b0, 11'd0));
    sb.push_back(mk(NOP, 1'b0, 11'd0, LNOP, 1'b0, 11'd0));
    sb.push_back(mk(NOP, 1'b0, 11'd0, LNOP, 1'b0, 11'd0));
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got = sample(); checks++;
    if (masked(got) !== masked(exp_o)) begin errors++; $display("FAIL flush_c1 got=%h exp=%h", got, exp_o); end
    drive('0, '0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (pc_enable !== 1'b1) begin errors++; $display("FAIL flush_pc_enable got=%b exp=1", pc_enable); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      exp_o = sb.pop_front(); got = sample(); checks++;
      if (masked(got) !== masked(exp_o)) begin errors++; $display("FAIL flush_c%0d got=%h exp=%h", c + 2, got, exp_o); end
      drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_stall_split();
    drive(32'h1000_0007, 32'h0000_0200, 11'd40, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(NOP, 1'b0, 11'd0, 32'h1000_0007, 1'b1, 11'd40));
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got = sample(); checks++;
    if (masked(got) !== masked(exp_o)) begin errors++; $display("FAIL stall_c1 got=%h exp=%h", got, exp_o); end
    for (int c = 0; c < 3; c++) begin
      drive(32'h0000_0081, 32'h1000_0102, 11'd50, 1'b1, 1'b1, 1'b0);
      checks++;
      if (pc_enable !== 1'b0) begin errors++; $display("FAIL stall_pc_enable%0d got=%b exp=0", c, pc_enable); end
      sb.push_back(mk(NOP, 1'b0, 11'd0, 32'h1000_0007, 1'b1, 11'd40));
      @(posedge clk); #1;
      exp_o = sb.pop_front(); got = sample(); checks++;
      if (masked(got) !== masked(exp_o)) begin errors++; $display("FAIL stall_frozen%0d got=%h exp=%h", c, got, exp_o); end
    end
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc_enable !== 1'b1) begin errors++; $display("FAIL stall_release_pc_enable got=%b exp=1", pc_enable); end
    sb.push_back(mk(32'h0000_0200, 1'b1, 11'd41, LNOP, 1'b0, 11'd0));
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got = sample(); checks++;
    if (masked(got) !== masked(exp_o)) begin errors++; $display("FAIL stall_release got=%h exp=%h", got, exp_o); end
  endtask

  task automatic test_reset_mid_split();
    drive(32'h0000_0003, 32'h1000_0180, 11'd60, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    got = sample(); checks++;
    if (got !== mk(NOP, 1'b0, 11'd0, LNOP, 1'b0, 11'd0)) begin
      errors++; $display("FAIL reset_split got=%h", got);
    end
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    sb.push_back(mk(NOP, 1'b0, 11'd0, LNOP, 1'b0, 11'd0));
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got = sample(); checks++;
    if (masked(got) !== masked(exp_o)) begin errors++; $display("FAIL reset_split_discard got=%h exp=%h", got, exp_o); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_pair();
    test_raw_split();
    test_class_order_checked();
    test_back_to_back();
    test_flush_split();
    test_stall_split();
    test_reset_mid_split();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
